// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester main-memory arbiter.
// The state encoding is one-hot.
package mem_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_GRANT0  = 4'b0010,
    ST_GRANT1  = 4'b0100,
    ST_RELEASE = 4'b1000
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating 32-bit activity counters for mem_arbiter.
// This module is instantiated only when ARB_STATS_EN is defined.
module mem_arb_stats
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        grant0_entry,
  input  logic        grant1_entry,
  input  logic        wait_cycle,
  output logic [31:0] stat_grant0,
  output logic [31:0] stat_grant1,
  output logic [31:0] stat_wait
);

  // Each counter holds at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_wait   <= '0;
    end else begin
      if (grant0_entry && stat_grant0 != 32'hFFFF_FFFF)
        stat_grant0 <= stat_grant0 + 32'd1;
      if (grant1_entry && stat_grant1 != 32'hFFFF_FFFF)
        stat_grant1 <= stat_grant1 + 32'd1;
      if (wait_cycle && stat_wait != 32'hFFFF_FFFF)
        stat_wait <= stat_wait + 32'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin, burst-locked arbiter that shares the mem_prin port between two cache requesters.
// Defining ARB_STATS_EN adds the saturating grant and wait counters (stat_* ports).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_WORDS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [3:0]        req0_wstrb,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [3:0]        req1_wstrb,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_valid_MP,
  output logic [ADDR_W-1:0] mem_addr_MP,
  output logic [DATA_W-1:0] mem_wdata_MP,
  output logic [3:0]        mem_wstrb_MP,
  input  logic [DATA_W-1:0] mem_rdata_MP,
  input  logic              mem_ready_MP,
  output logic [1:0]        grant
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_grant0,
  output logic [31:0]       stat_grant1,
  output logic [31:0]       stat_wait
`endif
);

  localparam int CNT_W = $clog2(BURST_WORDS) + 1;

  arb_state_t       state, next_state;
  logic             rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             in_grant;
  logic             owner_valid;
  logic             last_beat;
  logic             exit_grant;

  always_comb begin
    in_grant    = (state == ST_GRANT0) || (state == ST_GRANT1);
    owner_valid = 1'b0;
    if (state == ST_GRANT0) owner_valid = req0_valid;
    if (state == ST_GRANT1) owner_valid = req1_valid;
    last_beat  = mem_ready_MP && (beat_cnt == CNT_W'(BURST_WORDS - 1));
    exit_grant = in_grant && (!owner_valid || last_beat);
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (req0_valid && req1_valid)
          next_state = (rr_ptr == REQ_D) ? ST_GRANT1 : ST_GRANT0;
        else if (req0_valid)
          next_state = ST_GRANT0;
        else if (req1_valid)
          next_state = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (exit_grant) next_state = ST_RELEASE;
      end
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  // An abandoned burst counts no further beats; either exit points rr_ptr at the other side.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr   <= REQ_I;
      beat_cnt <= '0;
    end else if (exit_grant) begin
      beat_cnt <= '0;
      rr_ptr   <= (state == ST_GRANT0) ? REQ_D : REQ_I;
    end else if (in_grant && mem_ready_MP) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // A ready that arrives after the owner has dropped valid is not forwarded.
  always_comb begin
    mem_valid_MP = 1'b0;
    mem_addr_MP  = '0;
    mem_wdata_MP = '0;
    mem_wstrb_MP = '0;
    req0_ready   = 1'b0;
    req0_rdata   = '0;
    req1_ready   = 1'b0;
    req1_rdata   = '0;
    grant        = '0;
    unique case (state)
      ST_GRANT0: begin
        mem_valid_MP = req0_valid;
        mem_addr_MP  = req0_addr;
        mem_wdata_MP = req0_wdata;
        mem_wstrb_MP = req0_wstrb;
        req0_ready   = mem_ready_MP && req0_valid;
        req0_rdata   = mem_rdata_MP;
        grant[REQ_I] = 1'b1;
      end
      ST_GRANT1: begin
        mem_valid_MP = req1_valid;
        mem_addr_MP  = req1_addr;
        mem_wdata_MP = req1_wdata;
        mem_wstrb_MP = req1_wstrb;
        req1_ready   = mem_ready_MP && req1_valid;
        req1_rdata   = mem_rdata_MP;
        grant[REQ_D] = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  logic grant0_entry;
  logic grant1_entry;
  logic wait_cycle;

  always_comb begin
    grant0_entry = (state == ST_IDLE) && (next_state == ST_GRANT0);
    grant1_entry = (state == ST_IDLE) && (next_state == ST_GRANT1);
    wait_cycle   = ((state == ST_GRANT0) && req1_valid) ||
                   ((state == ST_GRANT1) && req0_valid);
  end

  mem_arb_stats u_stats (
    .clk          (clk),
    .resetn       (resetn),
    .grant0_entry (grant0_entry),
    .grant1_entry (grant1_entry),
    .wait_cycle   (wait_cycle),
    .stat_grant0  (stat_grant0),
    .stat_grant1  (stat_grant1),
    .stat_wait    (stat_wait)
  );
`endif

endmodule
